// File: rtl/adc_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_capture_pkg
// Description : Shared widths, packed-word layout and packer state encoding
//               for the ADC capture write path.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_capture_pkg;

    localparam int SAMPLE_W   = 10;
    localparam int WORD_W     = 32;
    localparam int SLOTS      = 3;
    localparam int SLOT_IDX_W = $clog2(SLOTS);

    localparam logic [SLOT_IDX_W-1:0] LAST_SLOT = SLOT_IDX_W'(SLOTS - 1);

    localparam int OR_BIT    = 31;
    localparam int TRIG_BIT  = 30;
    localparam int SLOT0_LSB = 20;
    localparam int SLOT1_LSB = 10;
    localparam int SLOT2_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } packer_state_t;

    function automatic logic [WORD_W-1:0] pack_word(
        input logic                or_flag,
        input logic                trig_flag,
        input logic [SAMPLE_W-1:0] s0,
        input logic [SAMPLE_W-1:0] s1,
        input logic [SAMPLE_W-1:0] s2
    );
        logic [WORD_W-1:0] w;
        w                          = '0;
        w[OR_BIT]                  = or_flag;
        w[TRIG_BIT]                = trig_flag;
        w[SLOT0_LSB +: SAMPLE_W]   = s0;
        w[SLOT1_LSB +: SAMPLE_W]   = s1;
        w[SLOT2_LSB +: SAMPLE_W]   = s2;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/packer_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module      : packer_skid_fifo
// Description : Two-entry valid/ready buffer; a push while full is accepted
//               only when the head is leaving in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module packer_skid_fifo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push_valid,
    input  logic [WIDTH-1:0] i_push_data,
    output logic             o_push_ready,
    output logic             o_pop_valid,
    output logic [WIDTH-1:0] o_pop_data,
    input  logic             i_pop_ready,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [1:0]       r_count;

    logic w_push;
    logic w_pop;

    assign o_full       = (r_count == 2'd2);
    assign o_empty      = (r_count == 2'd0);
    assign o_pop_valid  = !o_empty;
    assign o_pop_data   = r_mem[r_rd_ptr];
    assign o_push_ready = !o_full || i_pop_ready;

    assign w_pop  = o_pop_valid && i_pop_ready;
    assign w_push = i_push_valid && o_push_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/adc_sample_packer.sv
`default_nettype none
// ============================================================================
// Module      : adc_sample_packer
// Description : Packs three 10-bit ADC samples per 32-bit word, counts the
//               capture against a latched length and drains to the DDR FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_sample_packer
    import adc_capture_pkg::*;
#(
    parameter int CNT_W = 30
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [SAMPLE_W-1:0] adc_data,
    input  logic                adc_or,
    input  logic                adc_trig,
    input  logic                capture_go,
    input  logic [CNT_W-1:0]    max_samples,
    output logic                capture_done,
    output logic [WORD_W-1:0]   word_data,
    output logic                word_valid,
    input  logic                word_ready,
    output logic                overflow,
    output logic [CNT_W-1:0]    samples_captured
);

    packer_state_t r_state;
    packer_state_t w_next_state;

    logic [CNT_W-1:0]      r_max;
    logic [CNT_W-1:0]      r_count;
    logic [SLOT_IDX_W-1:0] r_slot_idx;
    logic [SAMPLE_W-1:0]   r_slot0;
    logic [SAMPLE_W-1:0]   r_slot1;
    logic                  r_or;
    logic                  r_trig0;
    logic                  r_pend_valid;
    logic [WORD_W-1:0]     r_pend_word;
    logic                  r_overflow;

    logic                  w_start;
    logic                  w_take;
    logic                  w_last;
    logic                  w_emit;
    logic                  w_first_slot;
    logic [WORD_W-1:0]     w_word;
    logic                  w_push_ready;
    logic                  w_fifo_empty;
    logic                  w_fifo_full;

    assign w_start      = (r_state == ST_IDLE) && capture_go;
    assign w_take       = (r_state == ST_CAPTURE) && capture_go;
    assign w_last       = w_take && ((r_count + CNT_W'(1)) == r_max);
    assign w_emit       = w_take && ((r_slot_idx == LAST_SLOT) || w_last);
    assign w_first_slot = (r_slot_idx == '0);

    // Word as it would look if the current sample closed it; later slots zero.
    assign w_word = pack_word(
        w_first_slot ? adc_or   : (r_or | adc_or),
        w_first_slot ? adc_trig : r_trig0,
        w_first_slot ? adc_data : r_slot0,
        (r_slot_idx == SLOT_IDX_W'(1)) ? adc_data : (w_first_slot ? '0 : r_slot1),
        (r_slot_idx == LAST_SLOT) ? adc_data : '0
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (capture_go) begin
                    w_next_state = (max_samples == '0) ? ST_DONE : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (!capture_go) begin
                    w_next_state = ST_IDLE;
                end else if (w_last) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!capture_go) begin
                    w_next_state = ST_IDLE;
                end else if (w_fifo_empty && !r_pend_valid) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!capture_go) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // A closed word spends one cycle in the pending stage before entering the buffer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_max        <= '0;
            r_count      <= '0;
            r_slot_idx   <= '0;
            r_slot0      <= '0;
            r_slot1      <= '0;
            r_or         <= 1'b0;
            r_trig0      <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_word  <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_pend_valid <= w_emit;
            if (w_emit) begin
                r_pend_word <= w_word;
            end

            if (r_pend_valid && !w_push_ready) begin
                r_overflow <= 1'b1;
            end

            if (w_take) begin
                r_count <= r_count + CNT_W'(1);
                if (w_first_slot) begin
                    r_slot0 <= adc_data;
                    r_trig0 <= adc_trig;
                    r_or    <= adc_or;
                end else begin
                    r_or <= r_or | adc_or;
                end
                if (r_slot_idx == SLOT_IDX_W'(1)) begin
                    r_slot1 <= adc_data;
                end
                r_slot_idx <= w_emit ? '0 : (r_slot_idx + SLOT_IDX_W'(1));
            end

            if (w_start) begin
                r_max      <= max_samples;
                r_count    <= '0;
                r_slot_idx <= '0;
                r_overflow <= 1'b0;
            end
        end
    end

    packer_skid_fifo #(
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_push_valid (r_pend_valid),
        .i_push_data  (r_pend_word),
        .o_push_ready (w_push_ready),
        .o_pop_valid  (word_valid),
        .o_pop_data   (word_data),
        .i_pop_ready  (word_ready),
        .o_full       (w_fifo_full),
        .o_empty      (w_fifo_empty)
    );

    assign capture_done     = (r_state == ST_DONE);
    assign overflow         = r_overflow;
    assign samples_captured = r_count;

    logic w_unused;
    assign w_unused = w_fifo_full;

endmodule
`default_nettype wire
